// File: rtl/bus_pkg.sv
// Shared types and helpers for the shared-memory bus access controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;

    // Widest grant vector the one-hot helper can inspect.
    localparam int ONEHOT_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESPOND = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // True when exactly one bit of v is set. Callers zero-extend narrower vectors.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary index encoder with legality flag (idx_vld = exactly one bit set).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of onehot_vec.
// Ports: onehot_vec (in, Width) -> idx_dat (out, binary index), idx_vld (out, one-hot legal).
module onehot_to_index
    import bus_pkg::*;
#(
    parameter int Width = 4,
    parameter int IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] onehot_vec,
    output logic [IdxW-1:0]  idx_dat,
    output logic             idx_vld
);

    logic [ONEHOT_MAX_W-1:0] vec_ext;

    always_comb begin
        vec_ext              = '0;
        vec_ext[Width-1:0]   = onehot_vec;
        idx_vld              = is_onehot(vec_ext);
        // OR of set-bit positions; only meaningful when idx_vld is high.
        idx_dat              = '0;
        for (int i = 0; i < Width; i++) begin
            if (onehot_vec[i]) begin
                idx_dat = idx_dat | IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_access_controller.sv
// Runs one single-beat shared-memory transaction per one-hot grant and returns DONE/RDATA to the winner.
// Latency: grant sampled T0 -> MEM_EN T1 -> DONE T2+MemLatency; min period MemLatency+3 cycles.
// Backpressure: none on memory; a held grant parks the FSM in RELEASE until ACCESS changes.
// Ports: CLK/RST (sync, active-high); ACCESS/ADDR/WDATA/WE per-core requests (flattened);
//        DONE/RDATA/GRANT_ERR responses; MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_RDATA memory port.
module bus_access_controller
    import bus_pkg::*;
#(
    parameter int NumOfRequesters = 4,
    parameter int AddrWidth       = DEF_ADDR_WIDTH,
    parameter int DataWidth       = DEF_DATA_WIDTH,
    parameter int MemLatency      = 2
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NumOfRequesters-1:0]           ACCESS,
    input  logic [NumOfRequesters*AddrWidth-1:0] ADDR,
    input  logic [NumOfRequesters*DataWidth-1:0] WDATA,
    input  logic [NumOfRequesters-1:0]           WE,
    output logic [NumOfRequesters-1:0]           DONE,
    output logic [DataWidth-1:0]                 RDATA,
    output logic                                 GRANT_ERR,
    output logic                                 MEM_EN,
    output logic                                 MEM_WE,
    output logic [AddrWidth-1:0]                 MEM_ADDR,
    output logic [DataWidth-1:0]                 MEM_WDATA,
    input  logic [DataWidth-1:0]                 MEM_RDATA
);

    localparam int IdxW = (NumOfRequesters > 1) ? $clog2(NumOfRequesters) : 1;
    localparam int CntW = $clog2(MemLatency + 1);

    state_t                     state_q, state_nxt;
    logic [IdxW-1:0]            idx_q, idx_nxt;
    logic                       we_q, we_nxt;
    logic [CntW-1:0]            cnt_q, cnt_nxt;

    logic [NumOfRequesters-1:0] done_nxt;
    logic [DataWidth-1:0]       rdata_nxt;
    logic                       grant_err_nxt;
    logic                       mem_en_nxt;
    logic                       mem_we_nxt;
    logic [AddrWidth-1:0]       mem_addr_nxt;
    logic [DataWidth-1:0]       mem_wdata_nxt;

    logic [IdxW-1:0]            grant_idx;
    logic                       grant_vld;
    logic [AddrWidth-1:0]       sel_addr;
    logic [DataWidth-1:0]       sel_wdata;
    logic                       sel_we;
    logic [NumOfRequesters-1:0] latched_grant;
    logic                       eval_grant;

    onehot_to_index #(
        .Width (NumOfRequesters),
        .IdxW  (IdxW)
    ) u_onehot_to_index (
        .onehot_vec (ACCESS),
        .idx_dat    (grant_idx),
        .idx_vld    (grant_vld)
    );

    // Slices of the requesting core; only consumed when grant_vld is high.
    assign sel_addr      = ADDR[grant_idx*AddrWidth +: AddrWidth];
    assign sel_wdata     = WDATA[grant_idx*DataWidth +: DataWidth];
    assign sel_we        = WE[grant_idx];
    assign latched_grant = NumOfRequesters'(1) << idx_q;

    always_comb begin
        state_nxt     = state_q;
        idx_nxt       = idx_q;
        we_nxt        = we_q;
        cnt_nxt       = cnt_q;
        done_nxt      = '0;
        rdata_nxt     = RDATA;
        grant_err_nxt = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = MEM_WE;
        mem_addr_nxt  = MEM_ADDR;
        mem_wdata_nxt = MEM_WDATA;
        eval_grant    = 1'b0;

        unique case (state_q)
            IDLE: begin
                eval_grant = 1'b1;
            end
            ISSUE: begin
                cnt_nxt   = CntW'(MemLatency);
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt_q - CntW'(1);
                // Count of 1 marks the cycle MEM_RDATA is valid; DONE/RDATA appear next cycle.
                if (cnt_q == CntW'(1)) begin
                    if (!we_q) begin
                        rdata_nxt = MEM_RDATA;
                    end
                    done_nxt[idx_q] = 1'b1;
                    state_nxt       = RESPOND;
                end
            end
            RESPOND: begin
                state_nxt = RELEASE;
            end
            RELEASE: begin
                // A changed grant is evaluated in this same cycle so a new winner loses no time.
                if (ACCESS != latched_grant) begin
                    state_nxt  = IDLE;
                    eval_grant = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (eval_grant) begin
            if (grant_vld) begin
                idx_nxt       = grant_idx;
                we_nxt        = sel_we;
                mem_en_nxt    = 1'b1;
                mem_we_nxt    = sel_we;
                mem_addr_nxt  = sel_addr;
                mem_wdata_nxt = sel_wdata;
                state_nxt     = ISSUE;
            end else if (ACCESS != '0) begin
                grant_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            DONE      <= '0;
            RDATA     <= '0;
            GRANT_ERR <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            state_q   <= state_nxt;
            idx_q     <= idx_nxt;
            we_q      <= we_nxt;
            cnt_q     <= cnt_nxt;
            DONE      <= done_nxt;
            RDATA     <= rdata_nxt;
            GRANT_ERR <= grant_err_nxt;
            MEM_EN    <= mem_en_nxt;
            MEM_WE    <= mem_we_nxt;
            MEM_ADDR  <= mem_addr_nxt;
            MEM_WDATA <= mem_wdata_nxt;
        end
    end

endmodule
